// File: rtl/dmux4way16_stream.sv
// rtl/dmux4way16_stream.sv - 1-to-4 word router with per-channel holding register and valid/ready handshakes
module dmux4way16_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] c,
    output logic [15:0] d,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready,
    output logic        busy
);

    logic [15:0] r_data [4];
    logic [3:0]  r_full;

    logic [3:0]  w_sel_onehot;
    logic        w_accept;
    logic [3:0]  w_load;
    logic [3:0]  w_drain;

    always_comb begin
        w_sel_onehot         = 4'b0000;
        w_sel_onehot[in_sel] = 1'b1;
    end

    // A full slot can still take a word when its consumer empties it in the same cycle.
    assign in_ready = ~r_full[in_sel] | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_sel_onehot & {4{w_accept}};
    assign w_drain  = r_full & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Load wins over drain so back-to-back words see no bubble.
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                    r_full[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    assign a         = r_data[0];
    assign b         = r_data[1];
    assign c         = r_data[2];
    assign d         = r_data[3];
    assign out_valid = r_full;
    assign busy      = |r_full;

endmodule

// File: tb/tb_dmux4way16_stream.sv
// tb/tb_dmux4way16_stream.sv - directed and scoreboarded checks for dmux4way16_stream
module tb_dmux4way16_stream;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sb [4][$];

    dmux4way16_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ch_data(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    // Inputs change at the falling edge; outputs are stable there too.
    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] dat, input logic [3:0] ordy);
        in_valid  = v;
        in_sel    = s;
        in_data   = dat;
        out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [3:0] ov,
                             input logic [15:0] ea, input logic [15:0] eb,
                             input logic [15:0] ec, input logic [15:0] ed);
        check({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, ov});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, |ov});
        check({tag, ".a"}, {16'd0, a}, {16'd0, ea});
        check({tag, ".b"}, {16'd0, b}, {16'd0, eb});
        check({tag, ".c"}, {16'd0, c}, {16'd0, ec});
        check({tag, ".d"}, {16'd0, d}, {16'd0, ed});
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
        step();
        step();
        check_all("reset", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        reset = 1'b0;

        // Single load into channel c
        drive(1'b1, 2'd2, 16'hBEEF, 4'b0000);
        check("load_c.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_all("load_c", 4'b0100, 16'h0, 16'h0, 16'hBEEF, 16'h0);

        // Stall on full c, then redirect to a
        drive(1'b1, 2'd2, 16'h1234, 4'b0000);
        check("stall_c.in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check_all("stall_c", 4'b0100, 16'h0, 16'h0, 16'hBEEF, 16'h0);
        drive(1'b1, 2'd0, 16'h1234, 4'b0000);
        check("redirect_a.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_all("redirect_a", 4'b0101, 16'h1234, 16'h0, 16'hBEEF, 16'h0);

        // Stream 1..4 through b with its consumer always ready
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 2'd1, 16'(k), 4'b0010);
            check($sformatf("stream_b%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
            step();
            check_all($sformatf("stream_b%0d", k), 4'b0111, 16'h1234, 16'(k), 16'hBEEF, 16'h0);
        end
        drive(1'b0, 2'd1, 16'h9999, 4'b0010);
        step();
        check_all("drain_b", 4'b0101, 16'h1234, 16'h0004, 16'hBEEF, 16'h0);

        // Fill b and d, then drain everything at once
        drive(1'b1, 2'd3, 16'hDDDD, 4'b0000);
        step();
        drive(1'b1, 2'd1, 16'h5555, 4'b0000);
        step();
        check_all("all_full", 4'b1111, 16'h1234, 16'h5555, 16'hBEEF, 16'hDDDD);
        drive(1'b0, 2'd2, 16'h0BAD, 4'b1111);
        step();
        check_all("drain_all", 4'b0000, 16'h1234, 16'h5555, 16'hBEEF, 16'hDDDD);

        // Ready on empty channels and in_valid=0 change nothing
        drive(1'b0, 2'd3, 16'h0BAD, 4'b1111);
        step();
        check_all("idle", 4'b0000, 16'h1234, 16'h5555, 16'hBEEF, 16'hDDDD);

        // Same-cycle drain and load on a
        drive(1'b1, 2'd0, 16'hAAAA, 4'b0000);
        step();
        drive(1'b1, 2'd0, 16'hBBBB, 4'b0001);
        check("swap_a.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_all("swap_a", 4'b0001, 16'hBBBB, 16'h5555, 16'hBEEF, 16'hDDDD);

        // Reset overrides a load into full d
        drive(1'b1, 2'd3, 16'h7777, 4'b0000);
        step();
        reset = 1'b1;
        drive(1'b1, 2'd3, 16'hFFFF, 4'b0000);
        check("reset_load.in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check_all("reset_load", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        reset = 1'b0;

        // Randomised traffic against a per-channel scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic exp_ready;
            logic [3:0] exp_valid;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  16'($urandom), 4'($urandom_range(0, 15)));
            for (int i = 0; i < 4; i++) exp_valid[i] = (sb[i].size() != 0);
            exp_ready = !exp_valid[in_sel] || out_ready[in_sel];
            check("rnd.in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check("rnd.out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
            for (int i = 0; i < 4; i++) begin
                if (exp_valid[i] && out_ready[i]) begin
                    check($sformatf("rnd.deliver%0d", i), {16'd0, ch_data(i)}, {16'd0, sb[i][0]});
                    void'(sb[i].pop_front());
                end
            end
            if (in_valid && exp_ready) sb[in_sel].push_back(in_data);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rnd.final_valid%0d", i), {31'd0, out_valid[i]}, {31'd0, sb[i].size() != 0});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
